// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, counter-width helper and frame defaults.
// Imported by the TX sequencer and the baud counter (and later by the RX side).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;
    localparam int DEFAULT_STOP_BITS    = 1;

    // Counter width needed to count 0..clks_per_bit-1; clks_per_bit >= 2 keeps this >= 1.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit timing: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick at terminal count.
// Clear has priority so a new frame always starts a fresh bit period.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_counter: CLKS_PER_BIT must be >= 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = enable && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: accepts a byte over valid/ready and shifts out start, data (LSB first)
// and stop bits on a registered, idle-high line that reset forces high asynchronously.
//
//   state | meaning
//   IDLE  | line high, tx_ready asserted, waiting for tx_valid
//   START | line low for one bit period
//   DATA  | data bits LSB-first, one bit period each
//   STOP  | line high for STOP_BITS bit periods, then back to IDLE
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS,
    parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_sequencer: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_sequencer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_sequencer: STOP_BITS must be 1 or 2");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 ready_q, ready_d;

    logic accept;
    logic baud_clear;
    logic baud_enable;
    logic bit_tick;

    // ready is a register rather than a state decode so it stays low while reset is held.
    assign accept      = tx_valid && ready_q;
    assign baud_enable = (state_q != IDLE);

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign busy     = (state_q != IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (baud_clear),
        .enable (baud_enable),
        .tick   (bit_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        txd_d      = txd_q;
        baud_clear = 1'b0;

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (accept) begin
                    shift_d    = tx_data;
                    bit_cnt_d  = '0;
                    baud_clear = 1'b1;
                    txd_d      = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        txd_d     = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        // Next line level is the bit about to become shift_q[0].
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            ready_q   <= ready_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: 8N1 at 4 clocks/bit on one instance and
// 7 data / 2 stop bits at 2 clocks/bit on a second, with hand-computed frame images.
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic       tx_valid_a = 1'b0;
    logic [7:0] tx_data_a  = '0;
    logic       tx_ready_a;
    logic       txd_a;
    logic       busy_a;

    logic       tx_valid_b = 1'b0;
    logic [6:0] tx_data_b  = '0;
    logic       tx_ready_b;
    logic       txd_b;
    logic       busy_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(
        .CLKS_PER_BIT(4),
        .DATA_BITS   (8),
        .STOP_BITS   (1)
    ) dut_a (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid_a),
        .tx_data  (tx_data_a),
        .tx_ready (tx_ready_a),
        .txd      (txd_a),
        .busy     (busy_a)
    );

    uart_tx_sequencer #(
        .CLKS_PER_BIT(2),
        .DATA_BITS   (7),
        .STOP_BITS   (2)
    ) dut_b (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid_b),
        .tx_data  (tx_data_b),
        .tx_ready (tx_ready_b),
        .txd      (txd_b),
        .busy     (busy_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at accept edge + 1; frame holds frame bit i in exp[i] (start at bit 0).
    // Returns at the edge after the last frame cycle + 1, where the line must be idle again.
    task automatic check_frame(input string tag, input bit use_b, input logic [11:0] exp,
                               input int nbits, input int cpb);
        logic t, b, r;
        for (int k = 0; k < nbits * cpb; k++) begin
            t = use_b ? txd_b : txd_a;
            b = use_b ? busy_b : busy_a;
            r = use_b ? tx_ready_b : tx_ready_a;
            check_val($sformatf("%s_txd_c%0d", tag, k + 1), t, exp[k / cpb]);
            check_val($sformatf("%s_busy_c%0d", tag, k + 1), b, 1'b1);
            check_val($sformatf("%s_ready_c%0d", tag, k + 1), r, 1'b0);
            @(posedge clk);
            #1;
        end
        t = use_b ? txd_b : txd_a;
        b = use_b ? busy_b : busy_a;
        r = use_b ? tx_ready_b : tx_ready_a;
        check_val({tag, "_end_txd"}, t, 1'b1);
        check_val({tag, "_end_busy"}, b, 1'b0);
        check_val({tag, "_end_ready"}, r, 1'b1);
    endtask

    task automatic send_a(input logic [7:0] d);
        tx_data_a  = d;
        tx_valid_a = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles: line high, not busy, not ready.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_txd_a", txd_a, 1'b1);
            check_val("rst_busy_a", busy_a, 1'b0);
            check_val("rst_ready_a", tx_ready_a, 1'b0);
            check_val("rst_txd_b", txd_b, 1'b1);
            check_val("rst_ready_b", tx_ready_b, 1'b0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_ready_a", tx_ready_a, 1'b1);
        check_val("post_rst_ready_b", tx_ready_b, 1'b1);

        // No traffic: line stays idle.
        for (int i = 0; i < 100; i++) begin
            check_val("idle_txd", txd_a, 1'b1);
            check_val("idle_busy", busy_a, 1'b0);
            @(posedge clk);
            #1;
        end

        // Single byte 0xA5: frame 0,1,0,1,0,0,1,0,1,1.
        send_a(8'hA5);
        check_frame("a5", 1'b0, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 4);

        // Back-to-back with tx_valid held: 0x00 then 0xFF, second accept 41 cycles later.
        tx_data_a  = 8'h00;
        tx_valid_a = 1'b1;
        @(posedge clk);
        #1;
        tx_data_a = 8'hFF;
        check_frame("b2b0", 1'b0, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 4);
        @(posedge clk);
        #1;
        tx_valid_a = 1'b0;
        check_frame("b2b1", 1'b0, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 4);

        // Data hold: tx_data/tx_valid disturbed mid-frame must not alter or restart the frame.
        send_a(8'h3C);
        fork
            check_frame("hold", 1'b0, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 4);
            begin
                repeat (10) @(posedge clk);
                #1;
                tx_data_a  = 8'hFF;
                tx_valid_a = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                tx_valid_a = 1'b0;
            end
        join
        for (int i = 0; i < 5; i++) begin
            check_val("hold_no_accept", busy_a, 1'b0);
            @(posedge clk);
            #1;
        end

        // Reset during a DATA bit: line returns high without a clock edge.
        send_a(8'h00);
        repeat (14) @(posedge clk);
        #1;
        check_val("midrst_pre_txd", txd_a, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_async_txd", txd_a, 1'b1);
        check_val("midrst_async_busy", busy_a, 1'b0);
        check_val("midrst_async_ready", tx_ready_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_post_ready", tx_ready_a, 1'b1);
        check_val("midrst_post_busy", busy_a, 1'b0);
        send_a(8'h81);
        check_frame("r81", 1'b0, {2'b00, 1'b1, 8'h81, 1'b0}, 10, 4);

        // 7 data bits, 2 stop bits, 2 clocks/bit: 0x55 -> 0,1,0,1,0,1,0,1,1,1.
        tx_data_b  = 7'h55;
        tx_valid_b = 1'b1;
        @(posedge clk);
        #1;
        tx_valid_b = 1'b0;
        check_frame("p55", 1'b1, {2'b00, 2'b11, 7'h55, 1'b0}, 10, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
